val_src_fifo: RTL and testbench

VAL_SRC_FIFO -- requirements
Module: val_src_fifo

---
 rtl/val_src_fifo.sv | 94 +++++++++
 tb/tb_val_src_fifo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/val_src_fifo.sv
// val_src_fifo
// Byte FIFO that feeds a downstream value stage without a handshake. Each pop
// loads the head byte into a register (d) and pulses d_valid for one cycle.
// After every pop the pace timer is loaded with PACE and counts down. No further
// pop happens until the timer reaches zero, which throttles the output rate to
// one byte every PACE+1 cycles.
//
// Parameters
//   DEPTH    : entry count; power of two, at least 2
//   PACE     : idle cycles enforced after each pop (0..15)
// Ports
//   clk      : single clock; all state updates on the rising edge
//   rst      : synchronous reset, active low
//   in_data  : upstream byte
//   in_valid : in_data is offered
//   in_ready : FIFO can accept a byte (count < DEPTH)
//   d        : registered output byte; holds its value between pops
//   d_valid  : high for the single cycle after a pop
//   count    : current occupancy

module val_src_fifo #(
    parameter int DEPTH = 4,
    parameter int PACE  = 0,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [7:0]    d,
    output logic          d_valid,
    output logic [CW-1:0] count
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  PACE_INIT = 4'(PACE);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [3:0]    pace_cnt;
    logic          push;
    logic          pop;

    // in_ready depends only on registered occupancy. A full FIFO therefore
    // refuses a push even when a pop happens in the same cycle.
    assign in_ready = (count < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (count != '0) && (pace_cnt == 4'd0);

    // DEPTH is a power of two, so the pointers wrap naturally on overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pace_cnt <= 4'd0;
            d        <= 8'h00;
            d_valid  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (pop) begin
                d        <= mem[rd_ptr];
                d_valid  <= 1'b1;
                rd_ptr   <= rd_ptr + 1'b1;
                pace_cnt <= PACE_INIT;
            end else begin
                d_valid <= 1'b0;
                if (pace_cnt != 4'd0) begin
                    pace_cnt <= pace_cnt - 1'b1;
                end
            end

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset. An entry is read only after it has been written,
    // so stale contents never reach d.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_val_src_fifo.sv
module tb_val_src_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data_a, in_data_b;
    logic       in_valid_a, in_valid_b;
    logic       in_ready_a, in_ready_b;
    logic [7:0] d_a, d_b;
    logic       dv_a, dv_b;
    logic [2:0] count_a, count_b;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    always #5 clk = ~clk;

    val_src_fifo #(.DEPTH(4), .PACE(0)) u_a (
        .clk(clk), .rst(rst), .in_data(in_data_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .d(d_a), .d_valid(dv_a), .count(count_a)
    );

    val_src_fifo #(.DEPTH(4), .PACE(2)) u_b (
        .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .d(d_b), .d_valid(dv_b), .count(count_b)
    );

    // Record every byte the DUTs present with d_valid high.
    always @(negedge clk) begin
        if (dv_a) q_a.push_back(d_a);
        if (dv_b) q_b.push_back(d_b);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        in_data_a  = 8'h00;
        in_data_b  = 8'h00;
        step();
        step();
        rst = 1'b1;
        q_a.delete();
        q_b.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count_a !== 3'd0)  begin failures++; $display("FAIL reset_count_a got=%0d exp=0", count_a); end
        checks++; if (in_ready_a !== 1'b1) begin failures++; $display("FAIL reset_ready_a got=%b exp=1", in_ready_a); end
        checks++; if (d_a !== 8'h00)     begin failures++; $display("FAIL reset_d_a got=%h exp=00", d_a); end
        checks++; if (dv_a !== 1'b0)     begin failures++; $display("FAIL reset_dv_a got=%b exp=0", dv_a); end
        checks++; if (count_b !== 3'd0)  begin failures++; $display("FAIL reset_count_b got=%0d exp=0", count_b); end
        checks++; if (in_ready_b !== 1'b1) begin failures++; $display("FAIL reset_ready_b got=%b exp=1", in_ready_b); end
    endtask

    task automatic test_single_push();
        do_reset();
        in_data_a = 8'hA5; in_valid_a = 1'b1;
        step();
        in_valid_a = 1'b0;
        checks++; if (dv_a !== 1'b0 || count_a !== 3'd1)
            begin failures++; $display("FAIL single_e1 got dv=%b cnt=%0d exp dv=0 cnt=1", dv_a, count_a); end
        step();
        checks++; if (dv_a !== 1'b1 || d_a !== 8'hA5 || count_a !== 3'd0)
            begin failures++; $display("FAIL single_e2 got dv=%b d=%h cnt=%0d exp dv=1 d=a5 cnt=0", dv_a, d_a, count_a); end
        step();
        checks++; if (dv_a !== 1'b0 || d_a !== 8'hA5)
            begin failures++; $display("FAIL single_e3 got dv=%b d=%h exp dv=0 d=a5", dv_a, d_a); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            in_data_a = 8'(i); in_valid_a = 1'b1;
            step();
            if (i >= 2) begin
                checks++; if (dv_a !== 1'b1 || d_a !== 8'(i - 1))
                    begin failures++; $display("FAIL b2b_pop%0d got dv=%b d=%h exp dv=1 d=%h", i, dv_a, d_a, 8'(i - 1)); end
            end
            checks++; if (count_a !== 3'd1)
                begin failures++; $display("FAIL b2b_count%0d got=%0d exp=1", i, count_a); end
        end
        in_valid_a = 1'b0;
        step();
        checks++; if (dv_a !== 1'b1 || d_a !== 8'h06 || count_a !== 3'd0)
            begin failures++; $display("FAIL b2b_last got dv=%b d=%h cnt=%0d exp dv=1 d=06 cnt=0", dv_a, d_a, count_a); end
    endtask

    task automatic test_pace();
        logic [2:0] cnt_exp [12] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0};
        logic       dv_exp  [12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] d_exp   [12] = '{8'h00, 8'h10, 8'h10, 8'h10, 8'h20, 8'h20, 8'h20, 8'h30, 8'h30, 8'h30, 8'h40, 8'h40};
        logic [7:0] bytes   [4]  = '{8'h10, 8'h20, 8'h30, 8'h40};
        do_reset();
        for (int e = 0; e < 12; e++) begin
            if (e < 4) begin
                in_data_b = bytes[e]; in_valid_b = 1'b1;
            end else begin
                in_valid_b = 1'b0;
            end
            step();
            checks++; if (dv_b !== dv_exp[e] || d_b !== d_exp[e] || count_b !== cnt_exp[e])
                begin failures++; $display("FAIL pace_e%0d got dv=%b d=%h cnt=%0d exp dv=%b d=%h cnt=%0d",
                    e + 1, dv_b, d_b, count_b, dv_exp[e], d_exp[e], cnt_exp[e]); end
        end
    endtask

    task automatic test_full();
        logic [7:0] exp_q [7] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hEE};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            in_data_b = 8'hA1 + 8'(i); in_valid_b = 1'b1;
            step();
        end
        checks++; if (count_b !== 3'd4 || in_ready_b !== 1'b0)
            begin failures++; $display("FAIL full_fill got cnt=%0d rdy=%b exp cnt=4 rdy=0", count_b, in_ready_b); end
        in_data_b = 8'hEE;
        step();
        checks++; if (count_b !== 3'd4 || in_ready_b !== 1'b0 || dv_b !== 1'b0)
            begin failures++; $display("FAIL full_hold got cnt=%0d rdy=%b dv=%b exp cnt=4 rdy=0 dv=0", count_b, in_ready_b, dv_b); end
        step();
        checks++; if (count_b !== 3'd3 || in_ready_b !== 1'b1 || dv_b !== 1'b1 || d_b !== 8'hA3)
            begin failures++; $display("FAIL full_pop got cnt=%0d rdy=%b dv=%b d=%h exp cnt=3 rdy=1 dv=1 d=a3", count_b, in_ready_b, dv_b, d_b); end
        step();
        in_valid_b = 1'b0;
        checks++; if (count_b !== 3'd4)
            begin failures++; $display("FAIL full_accept got cnt=%0d exp=4", count_b); end
        for (int i = 0; i < 15; i++) step();
        checks++; if (q_b.size() !== 7 || count_b !== 3'd0)
            begin failures++; $display("FAIL full_drain got n=%0d cnt=%0d exp n=7 cnt=0", q_b.size(), count_b); end
        for (int i = 0; i < 7 && i < q_b.size(); i++) begin
            checks++; if (q_b[i] !== exp_q[i])
                begin failures++; $display("FAIL full_order%0d got=%h exp=%h", i, q_b[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_data_b = 8'h61 + 8'(i); in_valid_b = 1'b1;
            step();
        end
        checks++; if (count_b !== 3'd3)
            begin failures++; $display("FAIL mid_count got=%0d exp=3", count_b); end
        rst = 1'b0; in_data_b = 8'h55; in_valid_b = 1'b1;
        step();
        checks++; if (count_b !== 3'd0 || d_b !== 8'h00 || dv_b !== 1'b0 || in_ready_b !== 1'b1)
            begin failures++; $display("FAIL mid_reset got cnt=%0d d=%h dv=%b rdy=%b exp cnt=0 d=00 dv=0 rdy=1", count_b, d_b, dv_b, in_ready_b); end
        rst = 1'b1; q_b.delete();
        in_data_b = 8'h7F; in_valid_b = 1'b1;
        step();
        in_valid_b = 1'b0;
        step();
        checks++; if (dv_b !== 1'b1 || d_b !== 8'h7F)
            begin failures++; $display("FAIL mid_first got dv=%b d=%h exp dv=1 d=7f", dv_b, d_b); end
        for (int i = 0; i < 6; i++) step();
        checks++; if (q_b.size() !== 1 || count_b !== 3'd0)
            begin failures++; $display("FAIL mid_only got n=%0d cnt=%0d exp n=1 cnt=0", q_b.size(), count_b); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            in_data_a = 8'h30 + 8'(i); in_valid_a = 1'b1;
            step();
        end
        in_valid_a = 1'b0;
        for (int i = 0; i < 3; i++) step();
        checks++; if (q_a.size() !== 10 || count_a !== 3'd0)
            begin failures++; $display("FAIL wrap_len got n=%0d cnt=%0d exp n=10 cnt=0", q_a.size(), count_a); end
        for (int i = 0; i < 10 && i < q_a.size(); i++) begin
            checks++; if (q_a[i] !== 8'h30 + 8'(i))
                begin failures++; $display("FAIL wrap_order%0d got=%h exp=%h", i, q_a[i], 8'h30 + 8'(i)); end
        end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_back_to_back();
        test_pace();
        test_full();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
